// File: rtl/sr_seq_pkg.sv
// Shared definitions for the sequential right shifter: FSM state encodings and fill modes.
package sr_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic LOGICAL = 1'b0;
  localparam logic ARITH   = 1'b1;

endpackage

// File: rtl/sr_1.sv
// Combinational 1-bit right shifter, gate-level: s=1 gives {fill, a[WIDTH-1:1]}, s=0 passes a.
module sr_1 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic             fill,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  logic             s_n;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] keep;
  logic [WIDTH-1:0] move;

  assign src = {fill, a[WIDTH-1:1]};

  not u_not_1 (s_n, s);

  // Per bit: y = (a & ~s) | (src & s)
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    and u_and_keep (keep[i], a[i], s_n);
    and u_and_move (move[i], src[i], s);
    or  u_or_1     (y[i], keep[i], move[i]);
  end

endmodule

// File: rtl/sr_seq.sv
// Sequential right shifter: latches an operand on start and shifts it right one bit per clock,
// zero- or sign-filled, with a start/busy/done handshake.
module sr_seq
  import sr_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_SHIFT | shifting y right once per clock, count = shifts remaining
  // S_DONE  | one-cycle result strobe; start here is accepted back-to-back

  state_t           state, state_nxt;
  logic [AMT_W-1:0] count, count_nxt;
  logic             fill, fill_nxt;
  logic [WIDTH-1:0] y_nxt;
  logic [WIDTH-1:0] y_sh;
  logic             shift_en;
  logic             accept;

  assign shift_en = (state == S_SHIFT);

  sr_1 #(.WIDTH(WIDTH)) u_sr_1 (
    .a    (y),
    .fill (fill),
    .s    (shift_en),
    .y    (y_sh)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
      fill  <= 1'b0;
      y     <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      fill  <= fill_nxt;
      y     <= y_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    fill_nxt  = fill;
    y_nxt     = y_sh;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;

    case (state)
      S_IDLE: accept = start;
      S_SHIFT: begin
        busy      = 1'b1;
        count_nxt = count - 1'b1;
        if (count == AMT_W'(1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        accept = start;
        if (!start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Sign bit is sampled only here, so later shifts never re-read it.
    if (accept) begin
      y_nxt     = a;
      count_nxt = amt;
      fill_nxt  = (arith == ARITH) & a[WIDTH-1];
      state_nxt = (amt != '0) ? S_SHIFT : S_DONE;
    end
  end

endmodule

// File: tb/tb_sr_seq.sv
// Self-checking bench for sr_seq: scoreboard of expected results and done cycles, popped on done.
module tb_sr_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [1:0] amt;
  logic       arith;
  logic       busy;
  logic       done;
  logic [3:0] y;

  typedef struct {
    logic [3:0] y;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  sr_seq #(.WIDTH(4), .AMT_W(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .amt   (amt),
    .arith (arith),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] model(input logic [3:0] av, input logic [1:0] sh, input logic ar);
    logic signed [3:0] s;
    logic signed [3:0] r;
    s = av;
    if (ar) begin
      r = s >>> sh;
      return r;
    end
    return av >> sh;
  endfunction

  // Result and latency are checked whenever done is seen.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("y", y, e.y);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic [3:0] av, input logic [1:0] sv, input logic ar, input bit hold = 1'b0);
    @(negedge clk);
    a     = av;
    amt   = sv;
    arith = ar;
    start = 1'b1;
    sb.push_back('{model(av, sv, ar), cyc + 1 + int'(sv)});
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check("busy_in_done", busy, 0);
      end else begin
        check("busy_in_shift", busy, 1);
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    amt   = '0;
    arith = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_y", y, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // Reset mid-shift takes effect without a clock edge.
    @(negedge clk);
    a = 4'b1011; amt = 2'd3; arith = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_y", y, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_y", y, 0);

    issue(4'b1011, 2'd2, 1'b0);
    wait_done(8);
    repeat (2) @(negedge clk);
    check("hold_y", y, 4'b0010);
    check("hold_busy", busy, 0);

    issue(4'b1011, 2'd2, 1'b1);
    wait_done(8);
    issue(4'b1000, 2'd3, 1'b1);
    wait_done(8);
    issue(4'b0110, 2'd1, 1'b1);
    wait_done(8);
    issue(4'b1011, 2'd0, 1'b0);
    wait_done(8);

    // Start pulsed while busy must be ignored.
    issue(4'b1011, 2'd3, 1'b0);
    @(negedge clk);
    a = 4'b0110; amt = 2'd1; arith = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(8);
    repeat (2) @(negedge clk);
    check("ignored_idle_done", done, 0);

    // Start held through DONE: second op accepted with no idle gap.
    issue(4'b1011, 2'd2, 1'b1, 1'b1);
    a = 4'b0110; amt = 2'd1; arith = 1'b0;
    sb.push_back('{model(4'b0110, 2'd1, 1'b0), cyc + 2 + 1 + 1});
    wait_done(8);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b_busy", busy, 1);
    wait_done(8);

    for (int ai = 0; ai < 16; ai++)
      for (int si = 0; si < 4; si++)
        for (int mi = 0; mi < 2; mi++) begin
          issue(4'(ai), 2'(si), 1'(mi));
          wait_done(8);
        end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
